// File: rtl/qdma_descriptor_mux_axil_slave.sv
// AXI4-Lite register slave: four 32-bit control registers with byte-strobed
// writes, one outstanding write and one outstanding read, and a flat parallel
// view of all registers on reg_out.
module qdma_descriptor_mux_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [(2**(C_S_AXI_ADDR_WIDTH-2))*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int          IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int          NREG   = 2**IDX_W;
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [NREG-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic                                    aw_held_q, aw_held_d;
  logic [IDX_W-1:0]                        aw_idx_q, aw_idx_d;
  logic                                    w_held_q, w_held_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]           w_data_q, w_data_d;
  logic [STRB_W-1:0]                       w_strb_q, w_strb_d;
  logic                                    bvalid_q, bvalid_d;
  logic                                    rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic                                    run_q, run_d;

  logic aw_hs, w_hs, ar_hs;

  // Protection attributes carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // run_q holds every ready low while in reset and for the first edge after it.
  assign S_AXI_AWREADY = run_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = run_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = run_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = '0;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = '0;
  assign reg_out       = regs_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Write path: capture AW and W into holds, commit once both are present.
  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    run_d     = 1'b1;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    // The next-state holds merge a held half with one arriving this cycle,
    // so either arrival order (or both together) commits at the same edge.
    if (aw_held_d && w_held_d) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_strb_d[i]) regs_d[aw_idx_d][8*i +: 8] = w_data_d[8*i +: 8];
      end
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
  end

  // Read path: sample the pre-commit register value on AR handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
    end
  end

  // State registers with asynchronous reset discarding any open transaction.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      run_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      run_q     <= run_d;
    end
  end

endmodule

// File: tb/tb_qdma_descriptor_mux_axil_slave.sv
// Directed bench for the AXI4-Lite register slave.
module tb_qdma_descriptor_mux_axil_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [3:0]   araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [127:0] reg_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qdma_descriptor_mux_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with AW and W presented together; waits for and consumes B.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_go, w_go;
    bit   done;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      aw_go = awvalid & awready;
      w_go  = wvalid & wready;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      done = !awvalid && !wvalid;
    end
    if (!done) chk("write_addr_data_timeout", 1, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bvalid) begin
        chk("bresp", bresp, 2'b00);
        done = 1;
      end
      step();
    end
    if (!done) chk("bvalid_timeout", 1, 0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit done;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = arready;
      step();
    end
    if (!done) chk("ar_timeout", 1, 0);
    arvalid = 1'b0;
    d = 'x;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rvalid) begin
        d = rdata;
        chk("rresp", rresp, 2'b00);
        done = 1;
      end
      step();
    end
    if (!done) chk("rvalid_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Linear directed sequence.
  initial begin
    logic [31:0] rd;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_out", reg_out, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    step();
    chk("ready_after_first_edge", {awready, wready, arready}, 3'b111);

    // Four full writes and read-back
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, rd); chk("rd_reg0", rd, 32'h1);
    axi_read(4'h5, rd); chk("rd_reg1", rd, 32'h2);
    axi_read(4'hA, rd); chk("rd_reg2", rd, 32'h3);
    axi_read(4'hF, rd); chk("rd_reg3", rd, 32'h4);
    chk("reg_out_all", reg_out, 128'h00000004_00000003_00000002_00000001);

    // Byte strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    axi_write(4'h4, 32'h11223344, 4'h5);
    axi_read(4'h4, rd); chk("strobe_0x5", rd, 32'hAA22CC44);

    // W ahead of AW by three cycles
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", wready, 1);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wfirst_wready_low", wready, 0);
      chk("wfirst_awready_high", awready, 1);
      chk("wfirst_no_bvalid", bvalid, 0);
      step();
    end
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_aw_ready", awready, 1);
    step();
    awvalid = 1'b0;
    chk("wfirst_bvalid", bvalid, 1);
    chk("wfirst_reg2", reg_out[95:64], 32'h55);
    step();
    chk("wfirst_b_done", bvalid, 0);
    chk("wfirst_ready_back", {awready, wready}, 2'b11);

    // Backpressure on B and R
    bready = 1'b0; rready = 1'b0;
    awaddr = 4'hC; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    chk("bp_readies", {awready, wready, arready}, 3'b111);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valids", {bvalid, rvalid}, 2'b11);
      chk("bp_rdata", rdata, 32'hAA22CC44);
      chk("bp_readies_low", {awready, wready, arready}, 3'b000);
      step();
    end
    chk("bp_reg3", reg_out[127:96], 32'hDEADBEEF);
    bready = 1'b1; rready = 1'b1;
    step();
    chk("bp_released_valids", {bvalid, rvalid}, 2'b00);
    chk("bp_released_readies", {awready, wready, arready}, 3'b111);

    // Same-edge write commit and read of one register
    axi_write(4'h0, 32'h7, 4'hF);
    awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1;
    @(negedge clk);
    chk("same_edge_readies", {awready, wready, arready}, 3'b111);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_rvalid", rvalid, 1);
    chk("same_edge_old_value", rdata, 32'h7);
    chk("same_edge_reg_out", reg_out[31:0], 32'h9);
    step();
    axi_read(4'h0, rd); chk("same_edge_new_value", rd, 32'h9);

    // Reset with an address accepted but no data yet
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    chk("mid_aw_ready", awready, 1);
    step();
    awvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_reg_out", reg_out, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    step();
    rst = 1'b0;
    step();
    wdata = 32'hCAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_wready", wready, 1);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_bvalid", bvalid, 0);
      step();
    end
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", awready, 1);
    step();
    awvalid = 1'b0;
    chk("post_rst_bvalid", bvalid, 1);
    chk("post_rst_reg_out", reg_out, 128'h00000000_00000000_0000CAFE_00000000);
    step();
    axi_read(4'h4, rd); chk("post_rst_read", rd, 32'hCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
